// File: rtl/bus_master_pkg.sv
// rtl/bus_master_pkg.sv - shared state encoding and default widths for the block-copy bus master
package bus_master_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_LEN_W  = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RD   = 3'd2,
    CAP  = 3'd3,
    WR   = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/bus_master_dp.sv
// rtl/bus_master_dp.sv - src/dst/count/data registers for the copy engine
// Exposes next-cycle values so the top can register bus outputs without a cycle of lag.
module bus_master_dp #(
  parameter int ADDR_W = bus_master_pkg::DEF_ADDR_W,
  parameter int DATA_W = bus_master_pkg::DEF_DATA_W,
  parameter int LEN_W  = bus_master_pkg::DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_data_we,
  input  logic [ADDR_W-1:0] i_src,
  input  logic [ADDR_W-1:0] i_dst,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [DATA_W-1:0] i_data,
  output logic [ADDR_W-1:0] o_src_nxt,
  output logic [ADDR_W-1:0] o_dst_nxt,
  output logic [DATA_W-1:0] o_data_nxt,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_data;
  logic [LEN_W-1:0]  w_cnt_nxt;

  // Address increments wrap naturally at the register width.
  assign o_src_nxt  = i_load ? i_src : (i_step ? r_src + ADDR_W'(1) : r_src);
  assign o_dst_nxt  = i_load ? i_dst : (i_step ? r_dst + ADDR_W'(1) : r_dst);
  assign w_cnt_nxt  = i_load ? i_len : (i_step ? r_cnt - LEN_W'(1) : r_cnt);
  assign o_data_nxt = i_data_we ? i_data : r_data;
  assign o_last     = (r_cnt == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_src  <= '0;
      r_dst  <= '0;
      r_cnt  <= '0;
      r_data <= '0;
    end else begin
      r_src  <= o_src_nxt;
      r_dst  <= o_dst_nxt;
      r_cnt  <= w_cnt_nxt;
      r_data <= o_data_nxt;
    end
  end

endmodule

// File: rtl/bus_master_copy.sv
// rtl/bus_master_copy.sv - block-copy bus initiator; BUS_MASTER_FILL_EN adds pattern-fill mode
// Bus outputs are registered from the next state, so they line up with the state they belong to.
module bus_master_copy
  import bus_master_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_start,
  input  logic [ADDR_W-1:0] op_src,
  input  logic [ADDR_W-1:0] op_dst,
  input  logic [LEN_W-1:0]  op_len,
  output logic              op_busy,
  output logic              op_done,
  output logic              m_req,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_dout,
  input  logic              m_grant,
  input  logic [DATA_W-1:0] m_din
`ifdef BUS_MASTER_FILL_EN
  ,
  input  logic              op_fill,
  input  logic [DATA_W-1:0] op_pattern
`endif
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_fill;
  logic              w_load;
  logic              w_step;
  logic              w_capture;
  logic              w_data_we;
  logic [DATA_W-1:0] w_data;
  logic [ADDR_W-1:0] w_src_nxt;
  logic [ADDR_W-1:0] w_dst_nxt;
  logic [DATA_W-1:0] w_data_nxt;
  logic              w_last;

  logic              r_busy, r_done, r_req, r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_dout;
  logic              w_busy_nxt, w_done_nxt, w_req_nxt, w_wr_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_dout_nxt;

  assign w_load    = (r_state == IDLE) && op_start && (op_len != '0);
  assign w_step    = (r_state == WR) && m_grant;
  assign w_capture = (r_state == CAP) && m_grant;

`ifdef BUS_MASTER_FILL_EN
  logic r_fill;
  always_ff @(posedge clk) begin
    if (reset)       r_fill <= 1'b0;
    else if (w_load) r_fill <= op_fill;
  end
  assign w_fill    = r_fill;
  assign w_data_we = w_capture | (w_load & op_fill);
  assign w_data    = w_capture ? m_din : op_pattern;
`else
  assign w_fill    = 1'b0;
  assign w_data_we = w_capture;
  assign w_data    = m_din;
`endif

  bus_master_dp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_dp (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_data_we  (w_data_we),
    .i_src      (op_src),
    .i_dst      (op_dst),
    .i_len      (op_len),
    .i_data     (w_data),
    .o_src_nxt  (w_src_nxt),
    .o_dst_nxt  (w_dst_nxt),
    .o_data_nxt (w_data_nxt),
    .o_last     (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Losing grant anywhere in a word sends us back to REQ without advancing the counters.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (op_start) w_state_nxt = (op_len != '0) ? REQ : DONE;
      REQ:  if (m_grant) w_state_nxt = w_fill ? WR : RD;
      RD:   w_state_nxt = m_grant ? CAP : REQ;
      CAP:  w_state_nxt = m_grant ? WR : REQ;
      WR: begin
        if (!m_grant)   w_state_nxt = REQ;
        else if (w_last) w_state_nxt = DONE;
        else             w_state_nxt = w_fill ? WR : RD;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_req_nxt  = 1'b0;
    w_wr_nxt   = 1'b0;
    w_done_nxt = 1'b0;
    w_busy_nxt = (w_state_nxt != IDLE);
    w_addr_nxt = r_addr;
    w_dout_nxt = r_dout;
    case (w_state_nxt)
      REQ: w_req_nxt = 1'b1;
      RD, CAP: begin
        w_req_nxt  = 1'b1;
        w_addr_nxt = w_src_nxt;
      end
      WR: begin
        w_req_nxt  = 1'b1;
        w_wr_nxt   = 1'b1;
        w_addr_nxt = w_dst_nxt;
        w_dout_nxt = w_data_nxt;
      end
      DONE:    w_done_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_req  <= 1'b0;
      r_wr   <= 1'b0;
      r_addr <= '0;
      r_dout <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_req  <= w_req_nxt;
      r_wr   <= w_wr_nxt;
      r_addr <= w_addr_nxt;
      r_dout <= w_dout_nxt;
    end
  end

  assign op_busy = r_busy;
  assign op_done = r_done;
  assign m_req   = r_req;
  assign m_wr    = r_wr;
  assign m_addr  = r_addr;
  assign m_dout  = r_dout;

endmodule

// File: tb/tb_bus_master_copy.sv
// tb/tb_bus_master_copy.sv - directed scoreboard bench for bus_master_copy (BUS_MASTER_FILL_EN optional)
module tb_bus_master_copy;

  localparam int AW = 16;
  localparam int DW = 64;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          op_start;
  logic [AW-1:0] op_src, op_dst;
  logic [LW-1:0] op_len;
  logic          op_busy, op_done;
  logic          m_req, m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_dout;
  logic          m_grant;
  logic [DW-1:0] m_din = '0;
`ifdef BUS_MASTER_FILL_EN
  logic          op_fill;
  logic [DW-1:0] op_pattern;
`endif

  always #5 clk = ~clk;

  bus_master_copy dut (
    .clk        (clk),
    .reset      (reset),
    .op_start   (op_start),
    .op_src     (op_src),
    .op_dst     (op_dst),
    .op_len     (op_len),
    .op_busy    (op_busy),
    .op_done    (op_done),
    .m_req      (m_req),
    .m_wr       (m_wr),
    .m_addr     (m_addr),
    .m_dout     (m_dout),
    .m_grant    (m_grant),
    .m_din      (m_din)
`ifdef BUS_MASTER_FILL_EN
    ,
    .op_fill    (op_fill),
    .op_pattern (op_pattern)
`endif
  );

  logic [DW-1:0] mem [0:65535];

  // Registered slave read: data follows the address by one cycle.
  always @(posedge clk) m_din <= mem[m_addr];

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests = 0, n_fail = 0;
  int  n_wr = 0, n_req = 0, n_done = 0, n_wrcyc = 0;
  int  lat, base_wr, base_req, base_done, base_wrcyc;
  logic [AW-1:0] a0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample the cycle about to complete (inputs already driven), then advance one clock.
  task automatic tick();
    wr_t e;
    if (m_req)  n_req++;
    if (op_done) n_done++;
    if (m_wr)   n_wrcyc++;
    if (m_req && m_wr && m_grant) begin
      n_wr++;
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL wr_unexpected: observed write to %0h expected none", m_addr);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", {48'h0, m_addr}, {48'h0, e.addr});
        chk("wr_data", m_dout, e.data);
      end
    end
    @(negedge clk);
  endtask

  task automatic start_op(input logic [AW-1:0] src, input logic [AW-1:0] dst, input logic [LW-1:0] len);
    op_src   = src;
    op_dst   = dst;
    op_len   = len;
    op_start = 1'b1;
    tick();
    op_start = 1'b0;
  endtask

  task automatic wait_done(output int ticks, input int budget);
    ticks = 0;
    while (!op_done && ticks < budget) begin
      tick();
      ticks++;
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; op_start = 1'b0; op_src = '0; op_dst = '0; op_len = '0; m_grant = 1'b1;
`ifdef BUS_MASTER_FILL_EN
    op_fill = 1'b0; op_pattern = '0;
`endif
    mem[16'h0010] = 64'hA5A5_0000_0000_0001;
    mem[16'h0011] = 64'hA5A5_0000_0000_0002;
    mem[16'h0020] = 64'h1111_2222_3333_4444;
    for (int i = 0; i < 3; i++) mem[16'h0030 + i] = 64'h0BAD_0000_0000_0030 + 64'(i);
    mem[16'h0040] = 64'hCAFE_0000_0000_0040;
    mem[16'h0041] = 64'hCAFE_0000_0000_0041;

    @(negedge clk);
    tick();
    tick();
    chk("rst_req", m_req, 0);
    chk("rst_wr", m_wr, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_dout", m_dout, 0);
    chk("rst_busy", op_busy, 0);
    chk("rst_done", op_done, 0);
    reset = 1'b0;
    tick();

    // basic two-word copy, grant tied high
    push_exp(16'h8010, 64'hA5A5_0000_0000_0001);
    push_exp(16'h8011, 64'hA5A5_0000_0000_0002);
    base_wr = n_wr;
    start_op(16'h0010, 16'h8010, 8'd2);
    chk("basic_req_c1", m_req, 1);
    chk("basic_busy_c1", op_busy, 1);
    wait_done(lat, 50);
    chk("basic_done_lat", lat + 1, 8);
    tick();
    chk("basic_busy_after", op_busy, 0);
    chk("basic_done_pulse", op_done, 0);
    chk("basic_nwr", n_wr - base_wr, 2);
    chk("basic_q_empty", exp_q.size(), 0);

    // grant withheld for 5 cycles
    push_exp(16'h0120, 64'h1111_2222_3333_4444);
    base_wr = n_wr;
    m_grant = 1'b0;
    start_op(16'h0020, 16'h0120, 8'd1);
    a0 = m_addr;
    for (int i = 0; i < 5; i++) begin
      chk("gw_req", m_req, 1);
      chk("gw_addr", m_addr, a0);
      chk("gw_wr", m_wr, 0);
      tick();
    end
    m_grant = 1'b1;
    wait_done(lat, 50);
    chk("gw_done_lat", lat, 4);
    tick();
    chk("gw_nwr", n_wr - base_wr, 1);
    chk("gw_q_empty", exp_q.size(), 0);

    // grant dropped during word 2's write
    for (int i = 0; i < 3; i++) push_exp(16'h0230 + AW'(i), 64'h0BAD_0000_0000_0030 + 64'(i));
    base_wr = n_wr;
    start_op(16'h0030, 16'h0230, 8'd3);
    for (int i = 0; i < 6; i++) tick();
    chk("gd_wr2_wr", m_wr, 1);
    chk("gd_wr2_addr", m_addr, 16'h0231);
    m_grant = 1'b0;
    tick();
    chk("gd_drop_wr", m_wr, 0);
    chk("gd_drop_req", m_req, 1);
    m_grant = 1'b1;
    wait_done(lat, 50);
    chk("gd_done_lat", lat, 7);
    tick();
    chk("gd_nwr", n_wr - base_wr, 3);
    chk("gd_q_empty", exp_q.size(), 0);

    // zero-length command
    base_req = n_req;
    base_wr  = n_wr;
    start_op(16'h0000, 16'h0000, 8'd0);
    chk("z_done", op_done, 1);
    chk("z_busy", op_busy, 1);
    chk("z_req", m_req, 0);
    tick();
    chk("z_busy_after", op_busy, 0);
    chk("z_req_cycles", n_req - base_req, 0);
    chk("z_nwr", n_wr - base_wr, 0);

    // destination wraps past 16'hFFFF
    push_exp(16'hFFFF, 64'hCAFE_0000_0000_0040);
    push_exp(16'h0000, 64'hCAFE_0000_0000_0041);
    start_op(16'h0040, 16'hFFFF, 8'd2);
    wait_done(lat, 50);
    chk("wrap_done_lat", lat + 1, 8);
    tick();
    chk("wrap_q_empty", exp_q.size(), 0);

    // reset asserted while in CAP
    start_op(16'h0050, 16'h0350, 8'd2);
    tick();
    tick();
    chk("rc_cap_req", m_req, 1);
    chk("rc_cap_addr", m_addr, 16'h0050);
    reset = 1'b1;
    tick();
    chk("rc_req", m_req, 0);
    chk("rc_wr", m_wr, 0);
    chk("rc_addr", m_addr, 0);
    chk("rc_dout", m_dout, 0);
    chk("rc_busy", op_busy, 0);
    chk("rc_done", op_done, 0);
    reset = 1'b0;
    base_done = n_done;
    base_wr   = n_wr;
    for (int i = 0; i < 10; i++) tick();
    chk("rc_no_done", n_done - base_done, 0);
    chk("rc_no_wr", n_wr - base_wr, 0);

`ifdef BUS_MASTER_FILL_EN
    // pattern fill: one write cycle per word, no reads
    for (int i = 0; i < 4; i++) push_exp(16'h0400 + AW'(i), 64'hDEAD_BEEF_0000_0000);
    op_fill    = 1'b1;
    op_pattern = 64'hDEAD_BEEF_0000_0000;
    base_req   = n_req;
    base_wrcyc = n_wrcyc;
    start_op(16'h0777, 16'h0400, 8'd4);
    op_fill    = 1'b0;
    op_pattern = '0;
    wait_done(lat, 50);
    chk("fill_done_lat", lat + 1, 6);
    tick();
    chk("fill_wr_cycles", n_wrcyc - base_wrcyc, 4);
    chk("fill_req_cycles", n_req - base_req, 5);
    chk("fill_q_empty", exp_q.size(), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
